weight_stream_loader: RTL and testbench

//  Writer-side counterpart of the per-parameter weight sources. Accepts a valid/ready

---
 rtl/weight_stream_if.sv | 26 ++
 rtl/weight_stream_loader.sv | 119 +++++++++++
 tb/tb_weight_stream_loader.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/weight_stream_if.sv
// Weight loader bus: incoming beat stream plus the RAM write port.
interface weight_stream_if #(
  parameter int PRECISION      = 16,
  parameter int LANES_PER_WORD = 32,
  parameter int PARALLELISM    = 4,
  parameter int AWIDTH         = 4
);
  logic [PRECISION-1:0]                data_in [PARALLELISM];
  logic                                data_in_valid;
  logic                                data_in_ready;
  logic [AWIDTH-1:0]                   mem_addr;
  logic                                mem_we;
  logic [PRECISION*LANES_PER_WORD-1:0] mem_wdata;

  // Producer of weight beats, observer of the RAM port.
  modport master (
    output data_in, data_in_valid,
    input  data_in_ready, mem_addr, mem_we, mem_wdata
  );

  // The loader: consumes beats, drives the RAM port.
  modport slave (
    input  data_in, data_in_valid,
    output data_in_ready, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/weight_stream_loader.sv
// Packs PARALLELISM-lane beats into RAM words and writes DEPTH words from address 0.
module weight_stream_loader #(
  parameter int PRECISION      = 16,
  parameter int LANES_PER_WORD = 32,
  parameter int PARALLELISM    = 4,
  parameter int DEPTH          = 8,
  parameter int AWIDTH         = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  weight_stream_if.slave    bus,
  output logic              busy,
  output logic              done,
  output logic [AWIDTH-1:0] words_written
);
  localparam int BEATS  = LANES_PER_WORD / PARALLELISM;
  localparam int WORD_W = PRECISION * LANES_PER_WORD;
  localparam int BCW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t              state_q, state_d;
  logic [BCW-1:0]      beat_cnt;
  logic [AWIDTH-1:0]   word_cnt;
  logic [WORD_W-1:0]   shadow;
  logic [WORD_W-1:0]   packed_next;
  logic [AWIDTH-1:0]   mem_addr_q;
  logic                mem_we_q;
  logic [WORD_W-1:0]   mem_wdata_q;
  logic                ready;
  logic                accept;
  logic                last_beat;
  logic                last_word;
  logic                start_load;

  assign accept     = bus.data_in_valid & ready;
  assign last_beat  = (beat_cnt == BCW'(BEATS - 1));
  assign last_word  = (word_cnt == AWIDTH'(DEPTH - 1));
  assign start_load = start & (state_q != LOAD);

  assign bus.data_in_ready = ready;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_we        = mem_we_q;
  assign bus.mem_wdata     = mem_wdata_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: start launches a load, the final word's last beat ends it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    if (accept && last_beat && last_word) state_d = DONE;
      DONE:    if (start) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from registered state only, so ready never depends on valid.
  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state_q)
      LOAD:    begin ready = 1'b1; busy = 1'b1; end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Shadow word with the current beat merged into its lane slot.
  always_comb begin
    packed_next = shadow;
    for (int b = 0; b < BEATS; b++) begin
      if (beat_cnt == BCW'(b)) begin
        for (int j = 0; j < PARALLELISM; j++) begin
          packed_next[PRECISION*(b*PARALLELISM+j) +: PRECISION] = bus.data_in[j];
        end
      end
    end
  end

  // Stage p0->p1: accept beats into the shadow; on a full word issue the RAM write.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt      <= '0;
      word_cnt      <= '0;
      shadow        <= '0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      words_written <= '0;
    end else begin
      mem_we_q <= 1'b0;
      if (start_load) begin
        beat_cnt      <= '0;
        word_cnt      <= '0;
        words_written <= '0;
      end else if (accept) begin
        shadow <= packed_next;
        if (last_beat) begin
          beat_cnt      <= '0;
          mem_we_q      <= 1'b1;
          mem_addr_q    <= word_cnt;
          mem_wdata_q   <= packed_next;
          word_cnt      <= word_cnt + 1'b1;
          words_written <= words_written + 1'b1;
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_weight_stream_loader.sv
// Scoreboard bench for weight_stream_loader.
module tb_weight_stream_loader;
  localparam int PRECISION      = 16;
  localparam int LANES_PER_WORD = 32;
  localparam int PARALLELISM    = 4;
  localparam int DEPTH          = 8;
  localparam int AWIDTH         = $clog2(DEPTH) + 1;
  localparam int BEATS          = LANES_PER_WORD / PARALLELISM;
  localparam int WORD_W         = PRECISION * LANES_PER_WORD;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              busy;
  logic              done;
  logic [AWIDTH-1:0] words_written;

  weight_stream_if #(
    .PRECISION(PRECISION), .LANES_PER_WORD(LANES_PER_WORD),
    .PARALLELISM(PARALLELISM), .AWIDTH(AWIDTH)
  ) bus ();

  weight_stream_loader #(
    .PRECISION(PRECISION), .LANES_PER_WORD(LANES_PER_WORD),
    .PARALLELISM(PARALLELISM), .DEPTH(DEPTH), .AWIDTH(AWIDTH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus),
    .busy(busy), .done(done), .words_written(words_written)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [AWIDTH-1:0] addr;
    logic [WORD_W-1:0] data;
  } wr_t;

  wr_t sb[$];
  wr_t exp_wr;
  int  hs_in_word = 0;
  int  hs_total   = 0;
  bit  prev_hs    = 1'b0;

  task automatic check(input string tag, input logic [WORD_W-1:0] obs, input logic [WORD_W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: compare each RAM write against the scoreboard and its beat timing.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      check("wr_latency", {prev_hs, 8'(hs_in_word)}, {1'b1, 8'(BEATS)});
      hs_in_word = 0;
      if (sb.size() == 0) begin
        check("unexpected_we", bus.mem_we, 0);
      end else begin
        exp_wr = sb.pop_front();
        check("wr_addr", bus.mem_addr, exp_wr.addr);
        check("wr_data", bus.mem_wdata, exp_wr.data);
      end
    end
    if (rst) begin
      hs_in_word = 0;
      prev_hs    = 1'b0;
    end else begin
      prev_hs = bus.data_in_valid && bus.data_in_ready;
      if (prev_hs) begin
        hs_in_word++;
        hs_total++;
      end
    end
  end

  task automatic reset_values(input string tag);
    check({tag, "_ready"}, bus.data_in_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_we"}, bus.mem_we, 0);
    check({tag, "_ww"}, words_written, 0);
    check({tag, "_addr"}, bus.mem_addr, 0);
    check({tag, "_wdata"}, bus.mem_wdata, 0);
  endtask

  // Called just after an edge; leaves the bench just after the edge that took start.
  task automatic do_start(input string tag);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy"}, busy, 1);
    check({tag, "_done"}, done, 0);
    check({tag, "_ready"}, bus.data_in_ready, 1);
    check({tag, "_ww"}, words_written, 0);
  endtask

  // Drive n beats; lane j of beat i is the global lane index (or all-ones).
  task automatic stream(input int n, input bit toggle, input bit ones, input int start_at);
    int i = 0;
    int cyc = 0;
    bit ph = 1'b1;
    bit fired = 1'b0;
    logic [WORD_W-1:0] w = '0;
    while (i < n && cyc < 1000) begin
      bus.data_in_valid = toggle ? ph : 1'b1;
      ph = ~ph;
      if (i == start_at && !fired) begin
        start = 1'b1;
        fired = 1'b1;
      end else begin
        start = 1'b0;
      end
      for (int j = 0; j < PARALLELISM; j++)
        bus.data_in[j] = ones ? '1 : PRECISION'(i*PARALLELISM + j);
      if (bus.data_in_valid && bus.data_in_ready) begin
        for (int j = 0; j < PARALLELISM; j++)
          w[PRECISION*((i % BEATS)*PARALLELISM + j) +: PRECISION] = bus.data_in[j];
        if (i % BEATS == BEATS - 1) sb.push_back('{AWIDTH'(i / BEATS), w});
        i++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.data_in_valid = 1'b0;
    start = 1'b0;
    check("stream_beats", i, n);
  endtask

  // Sampled one edge after the final beat: last write and DONE coincide.
  task automatic completion(input string tag);
    check({tag, "_we"}, bus.mem_we, 1);
    check({tag, "_done"}, done, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ready"}, bus.data_in_ready, 0);
    check({tag, "_ww"}, words_written, DEPTH);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_sb_empty"}, sb.size(), 0);
    check({tag, "_done_held"}, done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    bus.data_in_valid = 1'b0;
    for (int j = 0; j < PARALLELISM; j++) bus.data_in[j] = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    reset_values("reset");

    // Beats offered in IDLE are never taken.
    bus.data_in_valid = 1'b1;
    for (int j = 0; j < PARALLELISM; j++) bus.data_in[j] = PRECISION'($urandom);
    repeat (10) @(posedge clk);
    #1;
    check("idle_ready", bus.data_in_ready, 0);
    check("idle_ww", words_written, 0);
    check("idle_hs", hs_total, 0);
    bus.data_in_valid = 1'b0;

    // Back-to-back full load.
    do_start("t1_start");
    stream(64, 1'b0, 1'b0, -1);
    completion("t1");

    // Reload from DONE with all-ones lanes.
    do_start("t6_start");
    stream(64, 1'b0, 1'b1, -1);
    completion("t6");

    // Valid toggling every cycle.
    do_start("t2_start");
    stream(64, 1'b1, 1'b0, -1);
    completion("t2");

    // Reset mid-load, with start in the same cycle.
    do_start("t4_start");
    stream(20, 1'b0, 1'b0, -1);
    rst   = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    rst   = 1'b0;
    start = 1'b0;
    reset_values("t4_rst");
    repeat (20) @(posedge clk);
    #1;
    check("t4_sb_empty", sb.size(), 0);
    check("t4_ww_idle", words_written, 0);
    check("t4_busy_idle", busy, 0);
    do_start("t4_restart");
    stream(64, 1'b0, 1'b0, -1);
    completion("t4");

    // start pulsed mid-load is ignored.
    do_start("t5_start");
    stream(64, 1'b0, 1'b0, 30);
    completion("t5");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
